// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and types shared by the FIFO read-side logic.
// Occupancy is a 2-bit enum sized from the skid-buffer depth.
package fifo_pkg;

  localparam int RD_BUF_DEPTH = 2;
  localparam int OCC_W        = $clog2(RD_BUF_DEPTH + 1);
  localparam int CNT_W        = 16;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready stream carrying FIFO read data downstream.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts the FIFO pop port (rdata/rempty/rinc) into a
// valid/ready stream through a 2-entry skid buffer that hides the one-cycle
// registered read latency of the FIFO memory.
// Optional macro FIFO_RD_STREAM_CNT_EN adds the 16-bit word_cnt output
// counting accepted beats (wraps at 16'hFFFF).
//
// state     | meaning
// ----------+---------------------------------------------
// OCC_EMPTY | no word buffered, m_valid low
// OCC_ONE   | one word buffered, presented on m_data
// OCC_TWO   | both entries full, further pops held off
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rinc,
  fifo_rd_stream_if.master m
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] word_cnt
`endif
);

  occ_e             occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] skid_q [RD_BUF_DEPTH];
  logic [WIDTH-1:0] skid_d [RD_BUF_DEPTH];
  logic             pop;
  logic             capture;
  logic [2:0]       credit_sum;

  assign pop     = m.valid & m.ready;
  assign capture = inflight_q;

  // Credit sum cannot underflow: pop implies at least one word is buffered.
  assign credit_sum = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign rinc       = rrst_n & ~rempty & (credit_sum < 3'(RD_BUF_DEPTH));

  assign m.valid = (occ_q != OCC_EMPTY);
  assign m.data  = skid_q[rd_ptr_q];

  // Next occupancy, pointers and in-flight flag.
  always_comb begin
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q ^ capture;
    rd_ptr_d   = rd_ptr_q ^ pop;
    inflight_d = rinc;
    unique case (occ_q)
      OCC_EMPTY: if (capture) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (capture && !pop)      occ_d = OCC_TWO;
        else if (!capture && pop) occ_d = OCC_EMPTY;
      end
      OCC_TWO:   if (pop) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // Returned FIFO word lands in the entry under the write pointer.
  always_comb begin
    skid_d = skid_q;
    if (capture) skid_d[wr_ptr_q] = rdata;
  end

  // Control state register; clears immediately on reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Data storage is not reset; it is only observed while m_valid is high.
  always_ff @(posedge rclk) begin
    skid_q <= skid_d;
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accepted-beat counter, wrapping naturally at its width.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(pop);
  end

  // Counter register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO read port modelled as a queue with registered
// rdata/rempty; expected beats are the words in the order the model popped them.
module tb_fifo_rd_stream;

  localparam int WIDTH = 8;

  logic             rclk   = 1'b0;
  logic             rrst_n = 1'b0;
  logic             rempty = 1'b1;
  logic [WIDTH-1:0] rdata  = '0;
  logic             rinc;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]      word_cnt;
`endif

  fifo_rd_stream_if #(.WIDTH(WIDTH)) m_if ();

  fifo_rd_stream #(.WIDTH(WIDTH)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .m      (m_if)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  int             n_cmp = 0;
  int             n_bad = 0;
  logic [7:0]     fifo_q[$];
  logic [7:0]     exp_q[$];
  bit             hold_empty = 1'b1;
  logic           pop_now;

  // FIFO read-side model: a pop sampled at the edge returns data one cycle later.
  always @(posedge rclk) begin
    pop_now = rinc;
    #1;
    if (pop_now && fifo_q.size() > 0) begin
      rdata = fifo_q.pop_front();
      exp_q.push_back(rdata);
    end
    rempty = hold_empty || (fifo_q.size() == 0);
  end

  task automatic apply_reset();
    @(negedge rclk);
    #2 rrst_n = 1'b0;
    #1;
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(posedge rclk);
    #2 rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    int got;
    m_if.ready = 1'b0;
    hold_empty = 1'b0;
    fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    repeat (4) begin
      @(negedge rclk);
      n_cmp++;
      if (rinc !== 1'b0) begin
        n_bad++; $display("FAIL reset_rinc: got %b expected 0", rinc);
      end
      n_cmp++;
      if (m_if.valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_valid: got %b expected 0", m_if.valid);
      end
    end
    @(posedge rclk);
    #2 rrst_n = 1'b1;
    @(negedge rclk);
    n_cmp++;
    if (rinc !== 1'b1) begin
      n_bad++; $display("FAIL release_rinc: got %b expected 1", rinc);
    end
    m_if.ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge rclk);
      if (m_if.valid === 1'b1) begin
        n_cmp++;
        if (m_if.data !== 8'hA0 + 8'(got)) begin
          n_bad++; $display("FAIL reset_drain: got %h expected %h", m_if.data, 8'hA0 + 8'(got));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_bad++; $display("FAIL reset_drain_count: got %0d expected 4", got);
    end
  endtask

  task automatic test_stream();
    hold_empty = 1'b1;
    m_if.ready = 1'b1;
    apply_reset();
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    @(negedge rclk);
    hold_empty = 1'b0;
    @(negedge rclk);
    n_cmp++;
    if (rinc !== 1'b1 || m_if.valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_first_rinc: got rinc=%b valid=%b expected rinc=1 valid=0", rinc, m_if.valid);
    end
    @(negedge rclk);
    n_cmp++;
    if (m_if.valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_latency: got valid=%b expected 0", m_if.valid);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge rclk);
      n_cmp++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'(i + 1)) begin
        n_bad++; $display("FAIL stream_beat: got valid=%b data=%h expected valid=1 data=%h", m_if.valid, m_if.data, 8'(i + 1));
      end
    end
    @(negedge rclk);
    n_cmp++;
    if (m_if.valid !== 1'b0 || rinc !== 1'b0) begin
      n_bad++; $display("FAIL stream_end: got valid=%b rinc=%b expected 0 0", m_if.valid, rinc);
    end
`ifdef FIFO_RD_STREAM_CNT_EN
    n_cmp++;
    if (word_cnt !== 16'd16) begin
      n_bad++; $display("FAIL stream_word_cnt: got %0d expected 16", word_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    int pulses;
    int got;
    hold_empty = 1'b1;
    m_if.ready = 1'b0;
    apply_reset();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    hold_empty = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge rclk);
      if (rinc === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++; $display("FAIL bp_rinc_pulses: got %0d expected 2", pulses);
    end
    repeat (4) begin
      @(negedge rclk);
      n_cmp++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'h01) begin
        n_bad++; $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=01", m_if.valid, m_if.data);
      end
    end
    @(posedge rclk);
    #2 m_if.ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      @(negedge rclk);
      if (m_if.valid === 1'b1) begin
        n_cmp++;
        if (m_if.data !== 8'(got + 1)) begin
          n_bad++; $display("FAIL bp_drain: got %h expected %h", m_if.data, 8'(got + 1));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 8) begin
      n_bad++; $display("FAIL bp_drain_count: got %0d expected 8", got);
    end
  endtask

  task automatic test_random();
    int         got;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    hold_empty = 1'b1;
    m_if.ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 1000; i++) fifo_q.push_back(8'($urandom));
    got = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      @(posedge rclk);
      #2;
      m_if.ready = 1'($urandom_range(0, 1));
      hold_empty = ($urandom_range(0, 3) == 0);
      @(negedge rclk);
      n_cmp++;
      if (exp_q.size() > 2) begin
        n_bad++; $display("FAIL rnd_occupancy: got %0d outstanding expected at most 2", exp_q.size());
      end
      if (prev_stall) begin
        n_cmp++;
        if (m_if.valid !== 1'b1 || m_if.data !== prev_data) begin
          n_bad++; $display("FAIL rnd_stable: got valid=%b data=%h expected valid=1 data=%h", m_if.valid, m_if.data, prev_data);
        end
      end
      if (m_if.valid === 1'b1 && exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_phantom: got valid=1 expected 0 with no word popped");
      end else if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (m_if.data !== e) begin
          n_bad++; $display("FAIL rnd_order: got %h expected %h at beat %0d", m_if.data, e, got);
        end
        got++;
      end
      prev_stall = (m_if.valid === 1'b1) && (m_if.ready === 1'b0);
      prev_data  = m_if.data;
    end
    n_cmp++;
    if (got != 1000 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL rnd_count: got %0d beats %0d left expected 1000 beats 0 left", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int got;
    hold_empty = 1'b1;
    m_if.ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h30 + 8'(i));
    hold_empty = 1'b0;
    repeat (6) @(negedge rclk);
    @(posedge rclk);
    #2 m_if.ready = 1'b1;
    @(posedge rclk);
    #2 m_if.ready = 1'b0;
    @(negedge rclk);
    n_cmp++;
    if (m_if.valid !== 1'b1 || m_if.data !== 8'h31) begin
      n_bad++; $display("FAIL mid_pre: got valid=%b data=%h expected valid=1 data=31", m_if.valid, m_if.data);
    end
    #2 rrst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_if.valid !== 1'b0 || rinc !== 1'b0) begin
      n_bad++; $display("FAIL mid_async: got valid=%b rinc=%b expected 0 0", m_if.valid, rinc);
    end
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h50 + 8'(i));
    m_if.ready = 1'b1;
    repeat (2) begin
      @(negedge rclk);
      n_cmp++;
      if (m_if.valid !== 1'b0 || rinc !== 1'b0) begin
        n_bad++; $display("FAIL mid_hold: got valid=%b rinc=%b expected 0 0", m_if.valid, rinc);
      end
    end
    @(posedge rclk);
    #2 rrst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      @(negedge rclk);
      if (m_if.valid === 1'b1) begin
        n_cmp++;
        if (m_if.data !== 8'h50 + 8'(got)) begin
          n_bad++; $display("FAIL mid_restart: got %h expected %h", m_if.data, 8'h50 + 8'(got));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 8) begin
      n_bad++; $display("FAIL mid_restart_count: got %0d expected 8", got);
    end
  endtask

`ifdef FIFO_RD_STREAM_CNT_EN
  task automatic test_cnt_wrap();
    int got;
    hold_empty = 1'b1;
    m_if.ready = 1'b1;
    apply_reset();
    n_cmp++;
    if (word_cnt !== 16'd0) begin
      n_bad++; $display("FAIL cnt_reset: got %0d expected 0", word_cnt);
    end
    for (int i = 0; i < 65537; i++) fifo_q.push_back(8'(i));
    hold_empty = 1'b0;
    got = 0;
    for (int c = 0; c < 66000 && got < 65537; c++) begin
      @(negedge rclk);
      if (m_if.valid === 1'b1) got++;
    end
    @(negedge rclk);
    n_cmp++;
    if (got != 65537 || word_cnt !== 16'd1) begin
      n_bad++; $display("FAIL cnt_wrap: got %0d beats word_cnt=%0d expected 65537 beats word_cnt=1", got, word_cnt);
    end
  endtask
`endif

  initial begin
    m_if.ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef FIFO_RD_STREAM_CNT_EN
    test_cnt_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
